// File: rtl/uart_mmio_periph.sv
// Memory-mapped 8N1 UART sharing the MEM-stage data bus: TXD/RXD/CON registers,
// independent transmitter and receiver, registered interrupt on TX-done / RX-valid.
module uart_mmio_periph #(
    parameter int          CLKS_PER_BIT = 10417,
    parameter logic [31:0] ADDR_TXD     = 32'h4000_0018,
    parameter logic [31:0] ADDR_RXD     = 32'h4000_001C,
    parameter logic [31:0] ADDR_CON     = 32'h4000_0020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    output logic        in_range,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] C_BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_t;

    state_t          r_tx_state, w_tx_state_nxt, r_rx_state, w_rx_state_nxt;
    logic [CW-1:0]   r_tx_cnt, w_tx_cnt_nxt, r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]      r_tx_idx, w_tx_idx_nxt, r_rx_idx, w_rx_idx_nxt;
    logic [7:0]      r_txd, r_rxd, r_rx_shift;
    logic            r_tx_ie, r_rx_ie, r_tx_done, r_rx_valid, r_irq, r_uart_tx;
    logic            r_rx_meta, r_rx_sync, r_rx_prev;
    logic            w_sel_txd, w_sel_rxd, w_sel_con, w_tx_busy, w_tx_store;
    logic            w_tx_bit_end, w_tx_done_evt, w_tx_line_nxt;
    logic            w_rx_s, w_rx_fall, w_rx_bit_end, w_rx_half_end, w_rx_load;
    logic [4:0]      w_con;
    logic            w_unused;

    assign w_sel_txd  = (Address == ADDR_TXD);
    assign w_sel_rxd  = (Address == ADDR_RXD);
    assign w_sel_con  = (Address == ADDR_CON);
    assign in_range   = w_sel_txd | w_sel_rxd | w_sel_con;
    assign w_tx_busy  = (r_tx_state != S_IDLE);
    assign w_con      = {w_tx_busy, r_rx_valid, r_tx_done, r_rx_ie, r_tx_ie};
    assign w_tx_store = MemWrite & w_sel_txd & ~w_tx_busy;
    assign uart_tx    = r_uart_tx;
    assign irq        = r_irq;
    assign w_unused   = ^Write_data[31:8];

    // Combinational read mux, same-cycle like the data memory.
    always_comb begin
        Read_data = 32'd0;
        if (MemRead) begin
            if (w_sel_rxd)      Read_data = {24'd0, r_rxd};
            else if (w_sel_txd) Read_data = {24'd0, r_txd};
            else if (w_sel_con) Read_data = {27'd0, w_con};
            else                Read_data = 32'd0;
        end else begin
            Read_data = 32'd0;
        end
    end

    assign w_tx_bit_end = (r_tx_cnt == C_BIT_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= 3'd0;
            r_uart_tx  <= 1'b1;
            r_txd      <= 8'd0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_idx   <= w_tx_idx_nxt;
            r_uart_tx  <= w_tx_line_nxt;
            if (w_tx_store) r_txd <= Write_data[7:0];
            else            r_txd <= r_txd;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_idx_nxt   = r_tx_idx;
        w_tx_done_evt  = 1'b0;
        case (r_tx_state)
            S_IDLE:  if (w_tx_store) begin w_tx_state_nxt = S_START; w_tx_idx_nxt = 3'd0; end
            S_START: if (w_tx_bit_end) begin w_tx_state_nxt = S_DATA; w_tx_idx_nxt = 3'd0; end
            S_DATA:  if (w_tx_bit_end) begin
                         if (r_tx_idx == 3'd7) w_tx_state_nxt = S_STOP;
                         else                  w_tx_idx_nxt   = r_tx_idx + 3'd1;
                     end
            S_STOP:  if (w_tx_bit_end) begin w_tx_state_nxt = S_IDLE; w_tx_done_evt = 1'b1; end
            default: w_tx_state_nxt = S_IDLE;
        endcase
        // Baud counter restarts on every bit boundary and in IDLE.
        if (r_tx_state == S_IDLE || w_tx_bit_end) w_tx_cnt_nxt = '0;
        else                                      w_tx_cnt_nxt = r_tx_cnt + 1'b1;
    end

    // Line level is registered from the next state so uart_tx has no decode glitches.
    always_comb begin
        case (w_tx_state_nxt)
            S_IDLE:  w_tx_line_nxt = 1'b1;
            S_START: w_tx_line_nxt = 1'b0;
            S_DATA:  w_tx_line_nxt = r_txd[w_tx_idx_nxt];
            S_STOP:  w_tx_line_nxt = 1'b1;
            default: w_tx_line_nxt = 1'b1;
        endcase
    end

    assign w_rx_s        = r_rx_sync;
    assign w_rx_fall     = r_rx_prev & ~w_rx_s;
    assign w_rx_bit_end  = (r_rx_cnt == C_BIT_END);
    assign w_rx_half_end = (r_rx_cnt == C_HALF_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= 3'd0;
            r_rx_shift <= 8'd0;
            r_rxd      <= 8'd0;
        end else begin
            r_rx_meta  <= uart_rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_idx   <= w_rx_idx_nxt;
            if (r_rx_state == S_DATA && w_rx_bit_end) r_rx_shift <= {w_rx_s, r_rx_shift[7:1]};
            else                                      r_rx_shift <= r_rx_shift;
            if (w_rx_load) r_rxd <= r_rx_shift;
            else           r_rxd <= r_rxd;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_idx_nxt   = r_rx_idx;
        case (r_rx_state)
            S_IDLE:  if (w_rx_fall) w_rx_state_nxt = S_START;
            S_START: if (w_rx_half_end) begin
                         w_rx_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                         w_rx_idx_nxt   = 3'd0;
                     end
            S_DATA:  if (w_rx_bit_end) begin
                         if (r_rx_idx == 3'd7) w_rx_state_nxt = S_STOP;
                         else                  w_rx_idx_nxt   = r_rx_idx + 3'd1;
                     end
            S_STOP:  if (w_rx_bit_end) w_rx_state_nxt = S_IDLE;
            default: w_rx_state_nxt = S_IDLE;
        endcase
        if (r_rx_state == S_IDLE || w_rx_bit_end || w_rx_state_nxt != r_rx_state) w_rx_cnt_nxt = '0;
        else                                                                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
    end

    // A byte is accepted only when the stop bit samples high.
    always_comb begin
        if (r_rx_state == S_STOP) w_rx_load = w_rx_bit_end & w_rx_s;
        else                      w_rx_load = 1'b0;
    end

    // Sticky flags: a set on the same edge as the clearing read wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_ie    <= 1'b0;
            r_rx_ie    <= 1'b0;
            r_tx_done  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (MemWrite && w_sel_con) {r_rx_ie, r_tx_ie} <= Write_data[1:0];
            else                       {r_rx_ie, r_tx_ie} <= {r_rx_ie, r_tx_ie};
            if (w_tx_done_evt)              r_tx_done <= 1'b1;
            else if (MemRead && w_sel_con)  r_tx_done <= 1'b0;
            else                            r_tx_done <= r_tx_done;
            if (w_rx_load)                  r_rx_valid <= 1'b1;
            else if (MemRead && w_sel_rxd)  r_rx_valid <= 1'b0;
            else                            r_rx_valid <= r_rx_valid;
            r_irq <= (r_tx_ie & r_tx_done) | (r_rx_ie & r_rx_valid);
        end
    end
endmodule
